// File: rtl/cla_pkg.sv
// Shared constants and FSM encoding for the word-serial carry-lookahead adder.
//   SliceWDefault    - default width of one lookahead slice
//   NumSlicesDefault - default number of slices per operand
//   state_e          - sequencer states
//   idx_width()      - width of the slice index counter (never below 1)
package cla_pkg;

  localparam int unsigned SliceWDefault    = 8;
  localparam int unsigned NumSlicesDefault = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_word_sequencer_if.sv
// Operand/result handshake bundle for cla_word_sequencer.
//   in_valid/in_ready   - operand handshake (a, b, carry_in)
//   out_valid/out_ready - result handshake (sum, carry_out, overflow)
// master: producer/consumer side; slave: the adder.
interface cla_word_sequencer_if #(
  parameter int unsigned TOTAL_W = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [TOTAL_W-1:0] a;
  logic [TOTAL_W-1:0] b;
  logic               carry_in;
  logic               out_valid;
  logic               out_ready;
  logic [TOTAL_W-1:0] sum;
  logic               carry_out;
  logic               overflow;

  modport master (
    output in_valid, a, b, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, a, b, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
endinterface

// File: rtl/carry_lookahead_adder.sv
// Purely combinational WIDTH-bit carry-lookahead adder.
//   a, b - addends
//   cin  - carry into bit 0
//   sum  - a + b + cin (mod 2^WIDTH)
//   cout - carry out of bit WIDTH-1
module carry_lookahead_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH:0]   carry;
  logic             acc;
  logic             chain;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is the flat sum-of-products of generate terms gated by the
  // propagate chain above them, so no carry depends on a previous carry.
  always_comb begin
    carry    = '0;
    acc      = 1'b0;
    chain    = 1'b1;
    carry[0] = cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      acc   = 1'b0;
      chain = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc   = acc | (chain & g[j]);
        chain = chain & p[j];
      end
      carry[i+1] = acc | (chain & cin);
    end
  end

  assign sum  = p ^ carry[WIDTH-1:0];
  assign cout = carry[WIDTH];

endmodule

// File: rtl/cla_word_sequencer.sv
// Word-serial adder: one SLICE_W-bit carry-lookahead slice per cycle.
//   clk, rst_n - clock and synchronous active-low reset
//   bus        - slave side of cla_word_sequencer_if
//                in:  in_valid, a, b, carry_in, out_ready
//                out: in_ready, out_valid, sum, carry_out, overflow
// Accept in IDLE, spend NUM_SLICES cycles in ADD (LSB slice first), then hold
// the result in DONE until out_ready.
module cla_word_sequencer
  import cla_pkg::*;
#(
  parameter int unsigned SLICE_W    = SliceWDefault,
  parameter int unsigned NUM_SLICES = NumSlicesDefault
) (
  input logic                 clk,
  input logic                 rst_n,
  cla_word_sequencer_if.slave bus
);

  localparam int unsigned TOTAL_W = SLICE_W * NUM_SLICES;
  localparam int unsigned IDX_W   = idx_width(NUM_SLICES);
  localparam int unsigned MSB     = TOTAL_W - 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_SLICES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TOTAL_W-1:0] a_q, a_d;
  logic [TOTAL_W-1:0] b_q, b_d;
  logic               carry_q, carry_d;
  logic [TOTAL_W-1:0] sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [31:0]        base;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  assign base    = 32'(idx_q) * SLICE_W;
  assign slice_a = a_q[base +: SLICE_W];
  assign slice_b = b_q[base +: SLICE_W];

  carry_lookahead_adder #(
    .WIDTH (SLICE_W)
  ) u_slice_adder (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.carry_in;
          idx_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        sum_d[base +: SLICE_W] = slice_sum;
        carry_d                = slice_cout;
        if (idx_q == LastIdx) begin
          // Top slice: its sum MSB is the word MSB, so flags resolve here.
          // The index is left at the last slice rather than wrapping.
          cout_d  = slice_cout;
          ovf_d   = (a_q[MSB] == b_q[MSB]) && (slice_sum[SLICE_W-1] != a_q[MSB]);
          state_d = StDone;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Self-checking bench for cla_word_sequencer at default parameters (32-bit word).
module tb_cla_word_sequencer;

  localparam int Lat    = 5;  // accepting edge plus one edge per slice
  localparam int Period = 6;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  cla_word_sequencer_if #(.TOTAL_W(32)) bus ();

  cla_word_sequencer #(
    .SLICE_W    (8),
    .NUM_SLICES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic; returns {overflow, carry_out, sum}.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c);
    logic [32:0] full;
    logic        ovf;
    full = {1'b0, x} + {1'b0, y} + {32'b0, c};
    ovf  = (x[31] == y[31]) && (full[31] != x[31]);
    return {ovf, full};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction from IDLE; hold>0 keeps out_ready low that many cycles in
  // DONE while offering a different operand that must be ignored.
  task automatic do_txn(input string name, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tc, input logic [31:0] es, input logic ec,
                        input logic eo, input int hold);
    int lat;
    chk({name, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.a        = ta;
    bus.b        = tb_v;
    bus.carry_in = tc;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      chk({name, "_busy_no_ready"}, 32'(bus.in_ready), 32'd0);
      step();
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'(Lat));
    chk({name, "_sum"}, bus.sum, es);
    chk({name, "_cout"}, 32'(bus.carry_out), 32'(ec));
    chk({name, "_ovf"}, 32'(bus.overflow), 32'(eo));
    for (int h = 0; h < hold; h++) begin
      bus.a        = ~ta;
      bus.in_valid = 1'b1;
      step();
      chk({name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({name, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({name, "_hold_sum"}, bus.sum, es);
      chk({name, "_hold_cout"}, 32'(bus.carry_out), 32'(ec));
      chk({name, "_hold_ovf"}, 32'(bus.overflow), 32'(eo));
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    // in_valid may still be high here: it must not be taken on the release edge.
    chk({name, "_released"}, 32'(bus.out_valid), 32'd0);
    chk({name, "_idle_after"}, 32'(bus.in_ready), 32'd1);
    chk({name, "_sum_kept"}, bus.sum, es);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [33:0] m;
    logic [31:0] ra, rb;
    logic        rc;
    logic [33:0] expq[$];
    int          last_acc;
    logic        took;

    checks        = 0;
    fails         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.carry_in  = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", bus.sum, 32'd0);
    chk("rst_cout", 32'(bus.carry_out), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);

    do_txn("small", 32'h0000001B, 32'h00000035, 1'b0, 32'h00000050, 1'b0, 1'b0, 0);
    do_txn("ripple", 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000001, 1'b1, 1'b0, 0);
    do_txn("ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 0);
    do_txn("negovf", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 0);
    do_txn("hold", 32'h12345678, 32'h0F0F0F0F, 1'b1, 32'h21436588, 1'b0, 1'b0, 3);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      m  = model(ra, rb, rc);
      do_txn("rand", ra, rb, rc, m[31:0], m[32], m[33], i % 3);
    end

    // Reset in the second ADD cycle discards the transaction.
    bus.a        = 32'hDEADBEEF;
    bus.b        = 32'h11111111;
    bus.carry_in = 1'b1;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_sum", bus.sum, 32'd0);
    chk("midrst_cout", 32'(bus.carry_out), 32'd0);
    chk("midrst_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midrst_no_pulse", 32'(bus.out_valid), 32'd0);
    end
    do_txn("after_rst", 32'h00000002, 32'h00000003, 1'b0, 32'h00000005, 1'b0, 1'b0, 0);

    // Back-to-back streaming with both valids held high.
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.carry_in  = 1'($urandom_range(0, 1));
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    last_acc      = -1;
    for (int c = 0; c < 36; c++) begin
      took = 1'b0;
      if (bus.out_valid) begin
        if (expq.size() == 0) begin
          chk("b2b_unexpected_result", 32'd1, 32'd0);
        end else begin
          m = expq.pop_front();
          chk("b2b_sum", bus.sum, m[31:0]);
          chk("b2b_cout", 32'(bus.carry_out), 32'(m[32]));
          chk("b2b_ovf", 32'(bus.overflow), 32'(m[33]));
        end
      end
      if (bus.in_ready) begin
        if (last_acc >= 0) chk("b2b_spacing", 32'(c - last_acc), 32'(Period));
        last_acc = c;
        expq.push_back(model(bus.a, bus.b, bus.carry_in));
        took = 1'b1;
      end
      step();
      if (took) begin
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.carry_in = 1'($urandom_range(0, 1));
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_drained", 32'(expq.size()), 32'd0);
    chk("b2b_accepts", 32'(last_acc), 32'd30);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
